// File: rtl/mips_pkg.sv
// mips_pkg
//   Shared definitions for the forwarding/hazard logic of the five-stage
//   MIPS pipeline: opcode constants, the 2-bit operand-select encoding,
//   the shadow destination record kept per pipeline stage, and a small
//   helper that decides whether a record produces a given source register.
package mips_pkg;

  localparam logic [5:0] OP_ALU  = 6'h00;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_JAL  = 6'h03;

  // EX-stage operand mux select
  typedef enum logic [1:0] {
    FWD_REG   = 2'b00,
    FWD_MEMWB = 2'b01,
    FWD_EXMEM = 2'b10
  } fwd_sel_t;

  // One shadow-pipeline slot: which register the instruction will write
  typedef struct packed {
    logic       valid;
    logic [4:0] dest;
    logic       is_load;
  } shadow_rec_t;

  localparam shadow_rec_t EMPTY_REC = '0;

  // A destination of r0 never produces a value worth forwarding
  function automatic logic rec_produces(input shadow_rec_t rec,
                                        input logic [4:0] src);
    return rec.valid && (rec.dest != 5'd0) && (rec.dest == src);
  endfunction

endpackage

// File: rtl/fwd_dest_decode.sv
// fwd_dest_decode
//   Combinational decode of the ID-stage instruction into the fields the
//   hazard unit needs.
//   Ports:
//     ir      in  32  instruction held in IFIDIR
//     dest    out 5   destination register (0 = none)
//     is_load out 1   instruction is LW
//     uses_rs out 1   rs (ir[25:21]) is read as a source
//     uses_rt out 1   rt (ir[20:16]) is read as a source
module fwd_dest_decode
  import mips_pkg::*;
(
  input  logic [31:0] ir,
  output logic [4:0]  dest,
  output logic        is_load,
  output logic        uses_rs,
  output logic        uses_rt
);

  logic [5:0] opcode;

  assign opcode = ir[31:26];

  // Unknown opcodes fall through with no destination and no sources
  always_comb begin
    dest    = 5'd0;
    is_load = 1'b0;
    uses_rs = 1'b0;
    uses_rt = 1'b0;
    case (opcode)
      OP_ALU: begin
        dest    = ir[15:11];
        uses_rs = 1'b1;
        uses_rt = 1'b1;
      end
      OP_LW: begin
        dest    = ir[20:16];
        is_load = 1'b1;
        uses_rs = 1'b1;
      end
      OP_ADDI: begin
        dest    = ir[20:16];
        uses_rs = 1'b1;
      end
      OP_SW: begin
        uses_rs = 1'b1;
      end
      OP_JAL: begin
        dest = 5'd31;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit
//   Forwarding and load-use hazard controller. Tracks the destination of
//   the instructions in EX, MEM and WB with a shadow pipeline, chooses the
//   EX operand sources for the instruction currently in ID (registered so
//   they line up with its EX cycle), and raises a one-cycle stall when the
//   ID instruction needs the result of a load that is still in EX.
//   Ports:
//     clock     in  1      pipeline clock, rising edge
//     rst_n     in  1      asynchronous active-low reset
//     id_valid  in  1      IFIDIR holds a real instruction
//     id_ir     in  32     instruction in ID
//     flush     in  1      kill the ID instruction
//     fa        out 2      ALU-A select, aligned to EX
//     fb        out 2      ALU-B select, aligned to EX
//     stall     out 1      combinational load-use stall
//     stall_cnt out CNT_W  saturating count of stall cycles
module fwd_hazard_unit
  import mips_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [31:0]      id_ir,
  input  logic             flush,
  output logic [1:0]       fa,
  output logic [1:0]       fb,
  output logic             stall,
  output logic [CNT_W-1:0] stall_cnt
);

  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  id_dest;
  logic        id_is_load;
  logic        uses_rs;
  logic        uses_rt;
  logic        enter;
  shadow_rec_t id_rec;
  shadow_rec_t ex_slot;
  shadow_rec_t mem_slot;
  shadow_rec_t wb_slot;
  fwd_sel_t    sel_a;
  fwd_sel_t    sel_b;

  assign rs = id_ir[25:21];
  assign rt = id_ir[20:16];

  fwd_dest_decode u_decode (
    .ir      (id_ir),
    .dest    (id_dest),
    .is_load (id_is_load),
    .uses_rs (uses_rs),
    .uses_rt (uses_rt)
  );

  assign id_rec = '{valid: 1'b1, dest: id_dest, is_load: id_is_load};

  // A load in EX has no data yet; flush overrides because the consumer dies
  assign stall = id_valid && !flush && ex_slot.is_load &&
                 ((uses_rs && rec_produces(ex_slot, rs)) ||
                  (uses_rt && rec_produces(ex_slot, rt)));

  assign enter = id_valid && !flush && !stall;

  // EX-slot producer is younger and wins; a load in EX never forwards
  always_comb begin
    sel_a = FWD_REG;
    sel_b = FWD_REG;
    if (uses_rs) begin
      if (rec_produces(ex_slot, rs) && !ex_slot.is_load)
        sel_a = FWD_EXMEM;
      else if (rec_produces(mem_slot, rs))
        sel_a = FWD_MEMWB;
    end
    if (uses_rt) begin
      if (rec_produces(ex_slot, rt) && !ex_slot.is_load)
        sel_b = FWD_EXMEM;
      else if (rec_produces(mem_slot, rt))
        sel_b = FWD_MEMWB;
    end
  end

  // Shadow pipeline shift; WB is tracked but needs no forwarding because
  // the register file is write-first
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      ex_slot  <= EMPTY_REC;
      mem_slot <= EMPTY_REC;
      wb_slot  <= EMPTY_REC;
    end else begin
      ex_slot  <= enter ? id_rec : EMPTY_REC;
      mem_slot <= ex_slot;
      wb_slot  <= mem_slot;
    end
  end

  // Selects follow the instruction into EX; bubbles read plain registers
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      fa <= FWD_REG;
      fb <= FWD_REG;
    end else begin
      fa <= enter ? sel_a : FWD_REG;
      fb <= enter ? sel_b : FWD_REG;
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n)
      stall_cnt <= '0;
    else if (stall && (stall_cnt != {CNT_W{1'b1}}))
      stall_cnt <= stall_cnt + 1'b1;
  end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// tb_fwd_hazard_unit
//   Directed test-plan sequences plus randomized instruction streams, all
//   checked against a reference model that keeps a short history of which
//   instruction entered EX on each of the last two cycles.
module tb_fwd_hazard_unit;
  import mips_pkg::*;

  localparam int CW      = 4;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic          clock;
  logic          rst_n;
  logic          id_valid;
  logic [31:0]   id_ir;
  logic          flush;
  logic [1:0]    fa;
  logic [1:0]    fb;
  logic          stall;
  logic [CW-1:0] stall_cnt;

  fwd_hazard_unit #(.CNT_W(CW)) dut (
    .clock     (clock),
    .rst_n     (rst_n),
    .id_valid  (id_valid),
    .id_ir     (id_ir),
    .flush     (flush),
    .fa        (fa),
    .fb        (fb),
    .stall     (stall),
    .stall_cnt (stall_cnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  typedef struct {
    bit valid;
    int dest;
    bit load;
  } hist_t;

  // hist[0] = what entered EX last cycle, hist[1] = the cycle before
  hist_t hist[$];
  int    model_cnt;
  int    exp_fa;
  int    exp_fb;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    if (observed != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic modelReset();
    hist_t e;
    e = '{valid: 0, dest: 0, load: 0};
    hist = {};
    hist.push_front(e);
    hist.push_front(e);
    model_cnt = 0;
    exp_fa = 0;
    exp_fb = 0;
  endtask

  // Instruction semantics straight from the opcode table
  function automatic void mdecode(input logic [31:0] ir, output int dest,
                                  output bit load, output bit urs, output bit urt);
    int op;
    op   = int'(ir[31:26]);
    dest = 0; load = 0; urs = 0; urt = 0;
    if (op == 'h00)      begin dest = int'(ir[15:11]); urs = 1; urt = 1; end
    else if (op == 'h23) begin dest = int'(ir[20:16]); urs = 1; load = 1; end
    else if (op == 'h08) begin dest = int'(ir[20:16]); urs = 1; end
    else if (op == 'h2B) begin urs = 1; end
    else if (op == 'h03) begin dest = 31; end
  endfunction

  function automatic int msel(input int s);
    if (s == 0) return 0;
    if (hist[0].valid && !hist[0].load && hist[0].dest == s) return 2;
    if (hist[1].valid && hist[1].dest == s) return 1;
    return 0;
  endfunction

  function automatic logic [31:0] r_type(input int rs_i, input int rt_i, input int rd_i);
    return {6'h00, 5'(rs_i), 5'(rt_i), 5'(rd_i), 11'h020};
  endfunction

  function automatic logic [31:0] i_type(input logic [5:0] op, input int rs_i, input int rt_i);
    return {op, 5'(rs_i), 5'(rt_i), 16'h0004};
  endfunction

  // Called on a falling edge: check registered outputs, drive, check stall,
  // advance the model, then wait for the next falling edge
  task automatic applyStimulus(input bit v, input logic [31:0] ir, input bit fl);
    int  dest;
    bit  load, urs, urt, exp_stall, enter;
    int  rs_i, rt_i;
    hist_t e;
    checkOutput("fa", int'(fa), exp_fa);
    checkOutput("fb", int'(fb), exp_fb);
    checkOutput("stall_cnt", int'(stall_cnt), model_cnt);
    id_valid = v;
    id_ir    = ir;
    flush    = fl;
    #1;
    mdecode(ir, dest, load, urs, urt);
    rs_i = int'(ir[25:21]);
    rt_i = int'(ir[20:16]);
    exp_stall = v && !fl && hist[0].valid && hist[0].load && hist[0].dest != 0 &&
                ((urs && rs_i == hist[0].dest) || (urt && rt_i == hist[0].dest));
    checkOutput("stall", int'(stall), int'(exp_stall));
    if (exp_stall && model_cnt < CNT_MAX) model_cnt++;
    enter  = v && !fl && !exp_stall;
    exp_fa = (enter && urs) ? msel(rs_i) : 0;
    exp_fb = (enter && urt) ? msel(rt_i) : 0;
    e = '{valid: enter, dest: dest, load: load};
    hist.push_front(e);
    void'(hist.pop_back());
    @(negedge clock);
  endtask

  task automatic doLoadUse();
    applyStimulus(1, i_type(OP_LW, 1, 8), 0);
    applyStimulus(1, r_type(8, 1, 9), 0);
    applyStimulus(1, r_type(8, 1, 9), 0);
  endtask

  function automatic int rreg();
    int k;
    k = int'($urandom_range(0, 4));
    return (k == 4) ? 31 : k;
  endfunction

  logic [5:0] ops [7];
  int cnt0;

  initial begin
    ops = '{OP_ALU, OP_LW, OP_SW, OP_ADDI, OP_J, OP_JAL, 6'h04};
    rst_n = 1'b0; id_valid = 1'b0; id_ir = '0; flush = 1'b0;
    modelReset();
    repeat (2) @(negedge clock);
    checkOutput("reset_fa", int'(fa), 0);
    checkOutput("reset_fb", int'(fb), 0);
    checkOutput("reset_stall", int'(stall), 0);
    checkOutput("reset_cnt", int'(stall_cnt), 0);
    rst_n = 1'b1;
    @(negedge clock);

    // EX-slot forward to A
    applyStimulus(1, r_type(1, 2, 3), 0);
    applyStimulus(1, r_type(3, 5, 4), 0);
    checkOutput("tp1_fa", int'(fa), 2);
    checkOutput("tp1_fb", int'(fb), 0);

    // MEM-slot forward to B across a NOP
    applyStimulus(1, r_type(1, 2, 3), 0);
    applyStimulus(1, 32'h0, 0);
    applyStimulus(1, r_type(7, 3, 6), 0);
    checkOutput("tp2_fa", int'(fa), 0);
    checkOutput("tp2_fb", int'(fb), 1);

    // Load-use: one stall then MEM forward
    cnt0 = model_cnt;
    doLoadUse();
    checkOutput("tp3_fa", int'(fa), 1);
    checkOutput("tp3_cnt", int'(stall_cnt), cnt0 + 1);

    // Flush beats stall
    cnt0 = model_cnt;
    applyStimulus(1, i_type(OP_LW, 1, 8), 0);
    applyStimulus(1, r_type(8, 1, 9), 1);
    checkOutput("tp4_fa", int'(fa), 0);
    checkOutput("tp4_fb", int'(fb), 0);
    checkOutput("tp4_cnt", int'(stall_cnt), cnt0);

    // r0 never forwards; JAL writes r31
    applyStimulus(1, i_type(OP_ADDI, 1, 0), 0);
    applyStimulus(1, r_type(0, 0, 2), 0);
    checkOutput("tp5_r0_fa", int'(fa), 0);
    checkOutput("tp5_r0_fb", int'(fb), 0);
    applyStimulus(1, {OP_JAL, 26'h10}, 0);
    applyStimulus(1, r_type(31, 1, 2), 0);
    checkOutput("tp5_jal_fa", int'(fa), 2);

    // Load in MEM slot: forward, no stall
    applyStimulus(1, i_type(OP_LW, 2, 8), 0);
    applyStimulus(1, 32'h0, 0);
    applyStimulus(1, r_type(1, 8, 9), 0);
    checkOutput("lw_mem_fb", int'(fb), 1);

    // Preload counter, then reset asynchronously in the middle of a stall
    while (model_cnt < CNT_MAX - 2) doLoadUse();
    applyStimulus(1, i_type(OP_LW, 1, 8), 0);
    id_valid = 1'b1; id_ir = r_type(8, 1, 9); flush = 1'b0;
    #1;
    checkOutput("mid_stall", int'(stall), 1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_fa", int'(fa), 0);
    checkOutput("async_fb", int'(fb), 0);
    checkOutput("async_stall", int'(stall), 0);
    checkOutput("async_cnt", int'(stall_cnt), 0);
    modelReset();
    @(negedge clock);
    rst_n = 1'b1;
    applyStimulus(1, r_type(8, 9, 2), 0);
    checkOutput("post_reset_fa", int'(fa), 0);
    checkOutput("post_reset_fb", int'(fb), 0);

    // Saturation
    repeat (CNT_MAX + 3) doLoadUse();
    checkOutput("sat_cnt", int'(stall_cnt), CNT_MAX);
    doLoadUse();
    checkOutput("sat_hold", int'(stall_cnt), CNT_MAX);

    // Randomized stream
    rst_n = 1'b0;
    #1;
    modelReset();
    @(negedge clock);
    rst_n = 1'b1;
    for (int i = 0; i < 600; i++) begin
      logic [31:0] ir;
      ir = {ops[$urandom_range(0, 6)], 5'(rreg()), 5'(rreg()), 5'(rreg()), 11'($urandom)};
      applyStimulus($urandom_range(0, 9) < 8, ir, $urandom_range(0, 9) < 1);
    end
    applyStimulus(0, 32'h0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
